// File: rtl/mapu_probe_tracer.sv
// Multi-channel probe tracer: circular capture of NUM_CH x CH_W probes with a
// mask/value trigger, PRE_TRIG pre-trigger samples and valid/ready readout.
module mapu_probe_tracer #(
  parameter int NUM_CH   = 4,
  parameter int CH_W     = 8,
  parameter int DEPTH    = 16,
  parameter int PRE_TRIG = 4
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        arm_i,
  input  logic                                        abort_i,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] trig_ch_sel_i,
  input  logic [CH_W-1:0]                             trig_mask_i,
  input  logic [CH_W-1:0]                             trig_val_i,
  input  logic [NUM_CH*CH_W-1:0]                      probe_i,
  output logic                                        rd_valid_o,
  input  logic                                        rd_ready_i,
  output logic [NUM_CH*CH_W-1:0]                      rd_data_o,
  output logic                                        rd_last_o,
  output logic [1:0]                                  state_o
);

  localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] PRE_C   = CW'(PRE_TRIG);
  localparam logic [CW-1:0] POST_C  = CW'(DEPTH - PRE_TRIG - 1);
  localparam logic [CW-1:0] LAST_C  = CW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                  state_q;
  logic [AW-1:0]           wp_q, rp_q, wp_d;
  logic [CW-1:0]           fill_q, fill_d;
  logic [CW-1:0]           cnt_q;
  logic [NUM_CH*CH_W-1:0]  mem_q [DEPTH];
  logic                    hit;
  logic                    we;

  // Out-of-range channel selects match no channel and so never trigger.
  always_comb begin
    hit = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (trig_ch_sel_i == SW'(k) &&
          (((probe_i[k*CH_W +: CH_W] ^ trig_val_i) & trig_mask_i) == '0))
        hit = 1'b1;
    end
  end

  assign wp_d   = wp_q + AW'(1);
  assign fill_d = (fill_q == DEPTH_C) ? fill_q : fill_q + CW'(1);
  assign we     = !abort_i && ((state_q == ARMED && !arm_i) || state_q == POST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wp_q    <= '0;
      rp_q    <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
    end else if (abort_i) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (arm_i) begin
            state_q <= ARMED;
            wp_q    <= '0;
            fill_q  <= '0;
          end
        end
        ARMED: begin
          if (arm_i) begin
            wp_q   <= '0;
            fill_q <= '0;
          end else begin
            wp_q   <= wp_d;
            fill_q <= fill_d;
            if (hit && fill_q >= PRE_C) begin
              // With no post-trigger samples the readout starts right away.
              if (POST_C == '0) begin
                state_q <= DONE;
                rp_q    <= wp_d;
                cnt_q   <= '0;
              end else begin
                state_q <= POST;
                cnt_q   <= POST_C;
              end
            end
          end
        end
        POST: begin
          wp_q  <= wp_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= DONE;
            rp_q    <= wp_d;
            cnt_q   <= '0;
          end
        end
        DONE: begin
          if (rd_ready_i) begin
            rp_q  <= rp_q + AW'(1);
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == LAST_C) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Trace storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[wp_q] <= probe_i;
  end

  assign rd_valid_o = (state_q == DONE);
  assign rd_data_o  = rd_valid_o ? mem_q[rp_q] : '0;
  assign rd_last_o  = rd_valid_o && (cnt_q == LAST_C);
  assign state_o    = state_q;

endmodule

// File: tb/tb_mapu_probe_tracer.sv
// Directed bench for mapu_probe_tracer: table-driven captures plus stall,
// reset, abort and restart sequences.
module tb_mapu_probe_tracer;

  logic        clk = 1'b0;
  logic        reset;
  logic        arm_i, abort_i;
  logic [1:0]  trig_ch_sel_i;
  logic [7:0]  trig_mask_i, trig_val_i;
  logic [31:0] probe_i;
  logic        rd_valid_o, rd_ready_i, rd_last_o;
  logic [31:0] rd_data_o;
  logic [1:0]  state_o;

  int total = 0;
  int bad   = 0;
  logic [7:0] ctr;

  typedef struct {
    logic [7:0] mask;
    logic [7:0] val;
    logic [7:0] first;
  } vec_t;
  vec_t tbl [3];

  mapu_probe_tracer #(.NUM_CH(4), .CH_W(8), .DEPTH(16), .PRE_TRIG(4)) dut (
    .clk(clk), .reset(reset), .arm_i(arm_i), .abort_i(abort_i),
    .trig_ch_sel_i(trig_ch_sel_i), .trig_mask_i(trig_mask_i),
    .trig_val_i(trig_val_i), .probe_i(probe_i),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
    .rd_data_o(rd_data_o), .rd_last_o(rd_last_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [7:0] c);
    return {~c, c ^ 8'h5A, 8'hC3, c};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    step();
    ctr     = ctr + 8'd1;
    probe_i = mk(ctr);
  endtask

  task automatic arm_start(input logic [7:0] mask, input logic [7:0] val);
    trig_mask_i   = mask;
    trig_val_i    = val;
    trig_ch_sel_i = 2'd0;
    arm_i         = 1'b1;
    step();
    arm_i   = 1'b0;
    ctr     = 8'd0;
    probe_i = mk(ctr);
    check("armed_state", 32'(state_o), 32'd1);
  endtask

  task automatic run_until(input logic [1:0] st, input int budget);
    int n = 0;
    while (state_o != st && n < budget) begin
      tick();
      n++;
    end
    check("reach_state", 32'(state_o), 32'(st));
  endtask

  task automatic readout_full(input logic [7:0] first);
    rd_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("rd_valid", 32'(rd_valid_o), 32'd1);
      check("rd_data", rd_data_o, mk(first + 8'(i)));
      check("rd_last", 32'(rd_last_o), 32'(i == 15));
      step();
    end
    check("end_valid", 32'(rd_valid_o), 32'd0);
    check("end_state", 32'(state_o), 32'd0);
    check("end_data", rd_data_o, 32'd0);
  endtask

  initial begin
    tbl[0] = '{mask: 8'hFF, val: 8'h0A, first: 8'h06};
    tbl[1] = '{mask: 8'hFF, val: 8'h02, first: 8'hFE};
    tbl[2] = '{mask: 8'h00, val: 8'h00, first: 8'h00};

    reset = 1'b1; arm_i = 1'b0; abort_i = 1'b0; rd_ready_i = 1'b1;
    trig_ch_sel_i = 2'd0; trig_mask_i = 8'h00; trig_val_i = 8'h00;
    ctr = 8'd0; probe_i = mk(ctr);
    #1;
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_valid", 32'(rd_valid_o), 32'd0);
    check("rst_data", rd_data_o, 32'd0);
    check("rst_last", 32'(rd_last_o), 32'd0);
    step(); step();
    reset = 1'b0;
    step();
    check("idle_state", 32'(state_o), 32'd0);

    for (int t = 0; t < 3; t++) begin
      arm_start(tbl[t].mask, tbl[t].val);
      run_until(2'd3, 400);
      readout_full(tbl[t].first);
      step();
    end

    // Readout with rd_ready pattern 1,0,0,1 repeating.
    begin
      int beats = 0;
      int c = 0;
      arm_start(8'h00, 8'h00);
      run_until(2'd3, 100);
      while (beats < 16 && c < 100 && rd_valid_o) begin
        rd_ready_i = (c % 4 == 0) || (c % 4 == 3);
        check("stall_data", rd_data_o, mk(8'(beats)));
        check("stall_last", 32'(rd_last_o), 32'(beats == 15));
        if (rd_ready_i) beats++;
        step();
        c++;
      end
      check("stall_beats", 32'(beats), 32'd16);
      check("stall_state", 32'(state_o), 32'd0);
      check("stall_valid", 32'(rd_valid_o), 32'd0);
      rd_ready_i = 1'b1;
    end

    // Reset mid-POST and mid-DONE takes effect without a clock edge.
    arm_start(8'hFF, 8'h0A);
    run_until(2'd2, 100);
    tick(); tick();
    reset = 1'b1;
    #1;
    check("rst_post_state", 32'(state_o), 32'd0);
    check("rst_post_valid", 32'(rd_valid_o), 32'd0);
    step();
    reset = 1'b0;
    step();
    arm_start(8'hFF, 8'h0A);
    run_until(2'd3, 100);
    step(); step();
    reset = 1'b1;
    #1;
    check("rst_done_state", 32'(state_o), 32'd0);
    check("rst_done_valid", 32'(rd_valid_o), 32'd0);
    check("rst_done_data", rd_data_o, 32'd0);
    step();
    reset = 1'b0;
    step();
    arm_start(tbl[0].mask, tbl[0].val);
    run_until(2'd3, 100);
    readout_full(tbl[0].first);
    step();

    // Abort after five accepted beats.
    arm_start(8'hFF, 8'h0A);
    run_until(2'd3, 100);
    rd_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("abort_pre_data", rd_data_o, mk(8'h06 + 8'(i)));
      step();
    end
    check("abort_pre_valid", 32'(rd_valid_o), 32'd1);
    abort_i = 1'b1;
    rd_ready_i = 1'b0;
    step();
    abort_i = 1'b0;
    rd_ready_i = 1'b1;
    check("abort_valid", 32'(rd_valid_o), 32'd0);
    check("abort_state", 32'(state_o), 32'd0);
    check("abort_data", rd_data_o, 32'd0);
    step();

    // Restart while ARMED at counter 0x03 clears fill; early 0x02 matches are ignored.
    arm_start(8'hFF, 8'h02);
    tick(); tick(); tick();
    arm_i = 1'b1;
    step();
    arm_i = 1'b0;
    check("restart_state", 32'(state_o), 32'd1);
    probe_i = mk(8'h04);
    step();
    for (int i = 0; i < 3; i++) begin
      probe_i = mk(8'h02);
      step();
      check("restart_ignore", 32'(state_o), 32'd1);
    end
    probe_i = mk(8'h02);
    step();
    check("restart_trig", 32'(state_o), 32'd2);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    check("restart_abort", 32'(state_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mapu_probe_tracer.md
Name: mapu_probe_tracer

Overview:
- Parametrised multi-channel probe capture block for the Matrix APU.
- Samples NUM_CH internal probe channels of CH_W bits every clock into a circular trace buffer.
- Freezes the buffer around a programmable mask/value trigger, keeping PRE_TRIG samples before the trigger.
- Streams the DEPTH captured samples out over a valid/ready port for the environment's probe agent or a debug bridge.

Parameters:
- NUM_CH, 4, number of probe channels (>=1).
- CH_W, 8, width of each channel in bits (>=1).
- DEPTH, 16, trace buffer depth in samples. Must be a power of 2, >=2.
- PRE_TRIG, 4, samples retained before the trigger sample. Must satisfy 0 <= PRE_TRIG < DEPTH.

Ports:
- clk  in  1  sole clock; all logic samples on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- arm_i  in  1  single-cycle arm/restart request.
- abort_i  in  1  forces IDLE from any state.
- trig_ch_sel_i  in  max(1,$clog2(NUM_CH))  channel compared for the trigger.
- trig_mask_i  in  CH_W  bits participating in the compare.
- trig_val_i  in  CH_W  compare value.
- probe_i  in  NUM_CH*CH_W  probe vector; channel k occupies bits [k*CH_W +: CH_W].
- rd_valid_o  out  1  readout beat valid.
- rd_ready_i  in  1  readout beat accepted.
- rd_data_o  out  NUM_CH*CH_W  readout sample; same channel layout as probe_i.
- rd_last_o  out  1  final (DEPTH-th) readout beat.
- state_o  out  2  current state: IDLE=0, ARMED=1, POST=2, DONE=3.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; write pointer wp=0, read pointer rp=0; fill and post/read counters = 0.
  - All outputs 0, asserted immediately on reset assertion.
  - Buffer contents are not reset.
- IDLE:
  - No writes.
  - arm_i=1 -> ARMED next cycle, with wp=0 and fill=0.
- ARMED:
  - Each cycle: buf[wp]<=probe_i; wp<=wp+1 mod DEPTH; fill saturates at DEPTH.
  - Trigger condition: ((probe_i[sel] ^ trig_val_i) & trig_mask_i)==0 AND fill>=PRE_TRIG, where fill is the count before this cycle's write.
  - A matching sample with fill<PRE_TRIG is ignored.
  - On trigger, the trigger sample is written that cycle. The post-trigger counter loads DEPTH-PRE_TRIG-1.
    - If that value is 0 -> DONE; otherwise -> POST.
  - arm_i=1 while ARMED restarts: wp=0, fill=0; no trigger is evaluated that cycle.
  - trig_ch_sel_i >= NUM_CH never triggers.
- POST:
  - Write every cycle and decrement the counter.
  - The write that takes the counter from 1 to 0 is the last one -> DONE.
  - arm_i is ignored.
  - Total retained = PRE_TRIG + 1 + (DEPTH-PRE_TRIG-1) = DEPTH samples.
- DONE:
  - On entry: rp=wp, which is the oldest retained sample; read counter = 0.
  - rd_valid_o=1; rd_data_o=buf[rp].
  - Transfer occurs when rd_valid_o & rd_ready_i: rp<=rp+1 mod DEPTH and the counter increments.
  - rd_last_o = rd_valid_o & (read counter == DEPTH-1).
  - The transfer with rd_last_o -> IDLE; rd_valid_o=0 the next cycle.
  - While valid & !ready, rd_data_o and rd_last_o are held stable.
  - arm_i is ignored.
  - rd_data_o=0 and rd_last_o=0 whenever rd_valid_o=0.
- abort_i:
  - Highest priority: -> IDLE next cycle from any state, and no write that cycle.
  - abort_i and arm_i together -> IDLE.
- Readout latency: first beat valid in the cycle after the last POST write.
- Probe sample latency: probe_i in cycle N appears verbatim in the readout.
- No arithmetic beyond pointer wrap mod DEPTH; counters are $clog2(DEPTH)+1 bits wide.

Test Plan:
- All directed tests use DEPTH=16, PRE_TRIG=4, NUM_CH=4, CH_W=8. Channel 0 = 8-bit counter equal to 0 in the first ARMED cycle, incrementing each cycle.
- Mask 0xFF, val 0x0A, sel 0, rd_ready=1 -> 16 beats with ch0 = 0x06..0x15; rd_last_o on beat 16; state_o 3->0.
- Mask 0xFF, val 0x02 (fill=2<PRE_TRIG, ignored) -> triggers on the next 0x02 at the counter wrap; readout ch0 = 0xFE,0xFF,0x00,0x01,0x02..0x0D.
- Mask 0x00 -> triggers at fill=4; readout ch0 = 0x00..0x0F. Then rd_ready toggled 1,0,0,1,... -> exactly 16 beats, in order; data stable during stalls.
- Reset asserted mid-POST -> state_o=0 and rd_valid_o=0 without waiting for a clock edge. After release, arm + trigger at 0x0A reproduces test 1.
- abort_i after 5 accepted beats -> rd_valid_o=0 next cycle, state_o=0. arm_i while ARMED at counter 0x03 restarts fill -> a 0x02 match shortly after is ignored.
